// File: rtl/router_pkt_gen.sv
// Packet source for the 1xN router: emits header {len,addr}, payload and an
// even-XOR parity byte, stalling on router busy.
module router_pkt_gen #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 2,
    parameter int          LEN_W     = 6,
    parameter int          NUM_DEST  = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_mode,
    input  logic              cfg_err_inj,
    input  logic              busy,
    output logic [DATA_W-1:0] pkt_data,
    output logic              pkt_valid,
    output logic              ready,
    output logic              done,
    output logic              cfg_err,
    output logic [15:0]       pkt_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] PARITY  = 2'd3;

    localparam logic [ADDR_W:0] DEST_LIMIT = NUM_DEST[ADDR_W:0];

    logic [1:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic              mode_q;
    logic              err_q;
    logic [LEN_W-1:0]  idx;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [LEN_W-1:0]  idx_nxt;

    // Tap set chosen to reproduce the reference sequence A5,4B,96,2C.
    always_comb begin
        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[6] ^ lfsr[4] ^ lfsr[3]};
        acc_nxt  = acc ^ pkt_data;
        idx_nxt  = idx + LEN_W'(1);
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pkt_count <= '0;
            lfsr      <= LFSR_SEED;
            acc       <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            idx       <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    pkt_data  <= '0;
                    pkt_valid <= 1'b0;
                    if (start) begin
                        if ({1'b0, cfg_addr} < DEST_LIMIT) begin
                            len_q     <= cfg_len;
                            mode_q    <= cfg_mode;
                            err_q     <= cfg_err_inj;
                            pkt_data  <= {cfg_len, cfg_addr};
                            pkt_valid <= 1'b1;
                            acc       <= {cfg_len, cfg_addr};
                            state     <= HEADER;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        if (len_q == '0) begin
                            // accumulator still holds only the header here
                            pkt_data  <= err_q ? ~acc : acc;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end else begin
                            idx      <= '0;
                            pkt_data <= mode_q ? DATA_W'(lfsr) : '0;
                            state    <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        acc <= acc_nxt;
                        if (mode_q) lfsr <= lfsr_nxt;
                        if (idx == len_q - LEN_W'(1)) begin
                            pkt_data  <= err_q ? ~acc_nxt : acc_nxt;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end else begin
                            idx      <= idx_nxt;
                            pkt_data <= mode_q ? DATA_W'(lfsr_nxt) : DATA_W'(idx_nxt);
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        pkt_data  <= '0;
                        pkt_valid <= 1'b0;
                        done      <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
